// File: rtl/demux_bit_sequencer.sv
// demux_bit_sequencer
// Upstream driver for a 1-to-DATA_W demultiplexer. A parallel word is captured on an
// accepted load pulse and walked out one bit per slot: sel carries the channel index and
// ser_out carries the word bit for that channel, so bit k lands on demux output k.
// Each slot is held HOLD cycles and qualified by strobe. busy covers the SEND and DONE
// states; done pulses for one cycle after the final slot. All outputs are registered.
module demux_bit_sequencer #(
  parameter int DATA_W    = 8,
  parameter int SEL_W     = $clog2(DATA_W),
  parameter int HOLD      = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ser_out,
  output logic [SEL_W-1:0]  sel,
  output logic              strobe,
  output logic              busy,
  output logic              done
);

  // A zero hold time would leave a slot with no cycles at all; refuse to build it.
  if (HOLD < 1) begin : g_bad_hold
    $error("demux_bit_sequencer: HOLD must be >= 1");
  end

  // Hold counter only needs to reach HOLD-1; keep at least one bit so HOLD=1 still works.
  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD - 1);
  localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? SEL_W'(DATA_W - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  shadow;
  logic [SEL_W-1:0]   idx;
  logic [HC_W-1:0]    hold_cnt;
  logic [SEL_W-1:0]   next_idx;
  logic               last_hold;
  logic               last_idx;

  // Channel that follows the current one in walk order; the final index never steps,
  // so no wrap handling is needed here.
  always_comb begin
    next_idx  = MSB_FIRST ? (idx - SEL_W'(1)) : (idx + SEL_W'(1));
    last_hold = (hold_cnt == HOLD_LAST);
    last_idx  = (idx == LAST_IDX);
  end

  // Sequencer FSM with registered outputs: IDLE -> SEND (DATA_W*HOLD cycles) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so all updates in this edge
    // see the pre-edge values; mixing in blocking writes would make ordering matter.
    if (rst) begin
      state    <= S_IDLE;
      // NOTE: the shadow word is cleared on reset as well, so a discarded partial word
      // can never leak into a later burst or show up on a debug probe.
      shadow   <= '0;
      idx      <= '0;
      hold_cnt <= '0;
      ser_out  <= 1'b0;
      sel      <= '0;
      strobe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            // Capture the word and present slot 0 on the same edge; ser_out is taken
            // from data_in directly because shadow only becomes valid after this edge.
            shadow   <= data_in;
            idx      <= FIRST_IDX;
            hold_cnt <= '0;
            sel      <= FIRST_IDX;
            ser_out  <= data_in[FIRST_IDX];
            strobe   <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= S_SEND;
          end else begin
            ser_out  <= 1'b0;
            sel      <= '0;
            strobe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end
        end

        S_SEND: begin
          if (last_hold) begin
            hold_cnt <= '0;
            if (last_idx) begin
              // Final slot has run its full hold time: close the burst.
              state   <= S_DONE;
              ser_out <= 1'b0;
              sel     <= '0;
              strobe  <= 1'b0;
              busy    <= 1'b1;
              done    <= 1'b1;
            end else begin
              idx     <= next_idx;
              sel     <= next_idx;
              ser_out <= shadow[next_idx];
              strobe  <= 1'b1;
              busy    <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end

        S_DONE: begin
          // Single done cycle; a load seen here is dropped, nothing is queued.
          state   <= S_IDLE;
          ser_out <= 1'b0;
          sel     <= '0;
          strobe  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          idx      <= '0;
          hold_cnt <= '0;
          ser_out  <= 1'b0;
          sel      <= '0;
          strobe   <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// Bench for demux_bit_sequencer. Two instances run side by side: dut 0 with default
// parameters (LSB first, HOLD=1) and dut 1 with MSB_FIRST=1, HOLD=3. A reference model
// turns every accepted load into a timeline of expected output vectors keyed by clock
// edge; a monitor compares each DUT cycle against that timeline (or against all-zero
// idle outputs when nothing is expected).
module tb_demux_bit_sequencer;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef struct {
    int         cyc;   // edge after which this output vector must be present
    logic [6:0] outs;  // {busy, done, strobe, sel[2:0], ser_out}
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_v    [2];
  logic              load_v   [2];
  logic [DATA_W-1:0] data_v   [2];
  logic              ser_v    [2];
  logic [SEL_W-1:0]  sel_v    [2];
  logic              strobe_v [2];
  logic              busy_v   [2];
  logic              done_v   [2];

  // Requested inputs for the next edge, applied and modelled by tick().
  logic              req_rst  [2];
  logic              req_load [2];
  logic [DATA_W-1:0] req_data [2];

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   next_free [2];
  int   edge_cnt = 0;
  int   n_cmp    = 0;
  int   n_fail   = 0;

  demux_bit_sequencer #(.DATA_W(8), .SEL_W(3), .HOLD(1), .MSB_FIRST(1'b0)) u_dut_a (
    .clk(clk), .rst(rst_v[0]), .data_in(data_v[0]), .load(load_v[0]),
    .ser_out(ser_v[0]), .sel(sel_v[0]), .strobe(strobe_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  demux_bit_sequencer #(.DATA_W(8), .SEL_W(3), .HOLD(3), .MSB_FIRST(1'b1)) u_dut_b (
    .clk(clk), .rst(rst_v[1]), .data_in(data_v[1]), .load(load_v[1]),
    .ser_out(ser_v[1]), .sel(sel_v[1]), .strobe(strobe_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int hold_of(input int id);
    return (id == 0) ? 1 : 3;
  endfunction

  function automatic bit msb_of(input int id);
    return (id == 1);
  endfunction

  task automatic sb_push(input int id, input int cyc, input logic [6:0] outs);
    exp_t e;
    e.cyc  = cyc;
    e.outs = outs;
    if (id == 0) sb_a.push_back(e);
    else         sb_b.push_back(e);
  endtask

  // Reference model: what the inputs about to be sampled at edge e imply for the future.
  task automatic model_edge(input int id, input int e);
    int         hold;
    int         ch;
    logic [7:0] w;
    hold = hold_of(id);
    if (req_rst[id]) begin
      if (id == 0) sb_a.delete();
      else         sb_b.delete();
      next_free[id] = e + 1;
    end else if (req_load[id] && e >= next_free[id]) begin
      w = req_data[id];
      for (int k = 0; k < DATA_W; k++) begin
        ch = msb_of(id) ? (DATA_W - 1 - k) : k;
        for (int h = 0; h < hold; h++)
          sb_push(id, e + k * hold + h, {1'b1, 1'b0, 1'b1, 3'(ch), w[ch]});
      end
      sb_push(id, e + DATA_W * hold, 7'b110_0000);
      next_free[id] = e + DATA_W * hold + 2;
    end
  endtask

  // Drive the requested inputs for the next rising edge and update the model.
  task automatic tick();
    int e;
    @(negedge clk);
    e = edge_cnt + 1;
    for (int id = 0; id < 2; id++) begin
      model_edge(id, e);
      rst_v[id]  = req_rst[id];
      load_v[id] = req_load[id];
      data_v[id] = req_data[id];
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mon(input int id);
    logic [6:0] act;
    exp_t       e;
    bit         have;
    act  = {busy_v[id], done_v[id], strobe_v[id], sel_v[id], ser_v[id]};
    have = (id == 0) ? (sb_a.size() > 0) : (sb_b.size() > 0);
    if (have) e = (id == 0) ? sb_a[0] : sb_b[0];
    if (have && e.cyc <= edge_cnt) begin
      if (id == 0) void'(sb_a.pop_front());
      else         void'(sb_b.pop_front());
      check($sformatf("dut%0d cyc%0d burst", id, edge_cnt), {25'd0, act}, {25'd0, e.outs});
      check($sformatf("dut%0d cyc%0d timing", id, edge_cnt), e.cyc, edge_cnt);
    end else begin
      check($sformatf("dut%0d cyc%0d idle", id, edge_cnt), {25'd0, act}, 32'd0);
    end
  endtask

  // Monitor: sample both DUTs shortly after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int id = 0; id < 2; id++) mon(id);
    end
  end

  task automatic set_in(input int id, input bit r, input bit l, input logic [7:0] d);
    req_rst[id]  = r;
    req_load[id] = l;
    req_data[id] = d;
  endtask

  initial begin
    for (int id = 0; id < 2; id++) begin
      set_in(id, 1'b1, 1'b1, 8'hFF);
      rst_v[id]     = 1'b1;
      load_v[id]    = 1'b1;
      data_v[id]    = 8'hFF;
      next_free[id] = 0;
    end

    // Reset held two edges with load=1, data=FF: nothing may start.
    tick();
    set_in(0, 1'b0, 1'b0, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00);
    ticks(3);

    // Default params, word A6, LSB first.
    set_in(0, 1'b0, 1'b1, 8'b1010_0110);
    tick();
    set_in(0, 1'b0, 1'b0, 8'h00);
    ticks(12);

    // MSB first with HOLD=3, word 81.
    set_in(1, 1'b0, 1'b1, 8'h81);
    tick();
    set_in(1, 1'b0, 1'b0, 8'h00);
    ticks(28);

    // Loads while busy (SEND and DONE) are ignored; data changes after capture are harmless.
    set_in(0, 1'b0, 1'b1, 8'h0F);
    tick();
    set_in(0, 1'b0, 1'b0, 8'hF0);
    ticks(2);
    set_in(0, 1'b0, 1'b1, 8'hF0);
    tick();
    set_in(0, 1'b0, 1'b0, 8'hF0);
    ticks(5);
    set_in(0, 1'b0, 1'b1, 8'hF0);
    tick();
    set_in(0, 1'b0, 1'b0, 8'h00);
    ticks(4);

    // Reset in the fourth SEND cycle, then a clean burst of 01.
    set_in(0, 1'b0, 1'b1, 8'hFF);
    tick();
    set_in(0, 1'b0, 1'b0, 8'hFF);
    ticks(3);
    set_in(0, 1'b1, 1'b0, 8'hFF);
    tick();
    set_in(0, 1'b0, 1'b0, 8'h00);
    tick();
    set_in(0, 1'b0, 1'b1, 8'h01);
    tick();
    set_in(0, 1'b0, 1'b0, 8'h00);
    ticks(12);

    // Load held high: back-to-back bursts on both instances.
    set_in(0, 1'b0, 1'b1, 8'h55);
    set_in(1, 1'b0, 1'b1, 8'h55);
    ticks(60);
    set_in(0, 1'b0, 1'b0, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00);
    ticks(30);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      for (int id = 0; id < 2; id++)
        set_in(id, ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), 8'($urandom));
      tick();
    end
    set_in(0, 1'b0, 1'b0, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00);
    ticks(40);

    // Every expected slot must have been consumed.
    check("dut0 drain", sb_a.size(), 0);
    check("dut1 drain", sb_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
